// File: rtl/dmem_lane_ctrl.sv
// dmem_lane_ctrl
//   Byte-lane data memory with a valid/ready request port and a registered,
//   single-cycle response pulse. Handles byte/half/word/dword accesses with
//   sign or zero extension. Misaligned accesses are either rejected or, when
//   SPLIT_MISALIGN is set, executed; accesses that cross a word boundary take
//   two beats (word idx, then word idx+1 modulo DEPTH).
//
//   Ports
//     clk, rst_n        clock, synchronous active-low reset
//     req_valid/ready   request handshake; ready only while idle
//     req_we            1 = store, 0 = load
//     req_addr          byte address
//     req_size          00 byte, 01 half, 10 word, 11 dword
//     req_signed        sign-extend load result
//     req_wdata         store data, right-justified
//     resp_valid        one-cycle response pulse, no backpressure
//     resp_err          access rejected (qualifies resp_valid)
//     resp_rdata        load data, right-justified and extended
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | accepting requests; single-beat accesses complete from here
//   SPLIT | second beat of a word-crossing access (word idx+1)

module dmem_lane_ctrl #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int DEPTH          = 2048,
    parameter int SPLIT_MISALIGN = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata
);

    localparam int B     = DATA_W / 8;
    localparam int B2    = 2 * B;
    localparam int DW2   = 2 * DATA_W;
    localparam int OFF_W = $clog2(B);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SPLIT = 1'b1;

    // Lanes 0..N-1 set for an access of 2^sz bytes.
    function automatic logic [B-1:0] size_lanes(input logic [1:0] sz);
        logic [B-1:0] m;
        m = '0;
        for (int k = 0; k < B; k++) begin
            m[k] = (k < (1 << sz));
        end
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] lanes_to_bits(input logic [B-1:0] l);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < B; k++) begin
            r[8*k +: 8] = {8{l[k]}};
        end
        return r;
    endfunction

    // Keep the low N bytes of raw and fill the rest with the sign of the top
    // kept byte (or zero). For a full-width access nothing is filled.
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                                 input logic [1:0]        sz,
                                                 input logic              sgn);
        logic [B-1:0]      l;
        logic              sb;
        logic [DATA_W-1:0] r;
        l  = size_lanes(sz);
        sb = 1'b0;
        r  = '0;
        for (int k = 0; k < B; k++) begin
            if (l[k]) sb = raw[8*k+7];
        end
        for (int k = 0; k < B; k++) begin
            r[8*k +: 8] = l[k] ? raw[8*k +: 8] : {8{sgn & sb}};
        end
        return r;
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [0:0]        state_q, state_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    // Second-beat context captured at acceptance.
    logic [IDX_W-1:0]  sp_idx_q;
    logic [OFF_W-1:0]  sp_off_q;
    logic [1:0]        sp_size_q;
    logic              sp_signed_q;
    logic              sp_we_q;
    logic [DATA_W-1:0] sp_hi_data_q;
    logic [B-1:0]      sp_hi_be_q;
    logic [DATA_W-1:0] sp_lo_q;

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  req_idx_nxt;
    logic [B-1:0]      req_lanes;
    logic [3:0]        n_bytes;
    logic              illegal, misaligned, crossing, req_err, accept;
    logic [B2-1:0]     wide_be;
    logic [DW2-1:0]    wide_wdata;
    logic [DATA_W-1:0] rd_word_a;
    logic [DATA_W-1:0] ld_raw_a;
    logic [DATA_W-1:0] ld_raw_s;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [DATA_W-1:0] mem_wdata;
    logic [B-1:0]      mem_wbe;

    assign req_off     = req_addr[OFF_W-1:0];
    assign req_idx     = req_addr[OFF_W+IDX_W-1:OFF_W];
    assign req_idx_nxt = req_idx + IDX_W'(1);
    assign req_lanes   = size_lanes(req_size);
    assign n_bytes     = 4'd1 << req_size;

    assign illegal    = (req_size == 2'b11) && (DATA_W == 32);
    assign misaligned = (4'(req_off) & (n_bytes - 4'd1)) != 4'd0;
    assign crossing   = (5'(req_off) + 5'(n_bytes)) > 5'(B);
    assign req_err    = illegal || (misaligned && (SPLIT_MISALIGN == 0));

    assign req_ready  = (state_q == S_IDLE);
    assign accept     = req_valid && req_ready;

    // Data and byte enables placed across two adjacent words: the low half
    // goes to word idx, the high half (non-zero only when crossing) to idx+1.
    assign wide_be    = B2'(req_lanes) << req_off;
    assign wide_wdata = DW2'(req_wdata & lanes_to_bits(req_lanes)) << {req_off, 3'b000};

    assign rd_word_a  = mem_q[req_idx];
    assign ld_raw_a   = rd_word_a >> {req_off, 3'b000};
    assign ld_raw_s   = DATA_W'({mem_q[sp_idx_q], sp_lo_q} >> {sp_off_q, 3'b000});

    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = req_idx;
        mem_wdata = wide_wdata[DATA_W-1:0];
        mem_wbe   = wide_be[B-1:0];
        if (state_q == S_SPLIT) begin
            mem_we    = sp_we_q;
            mem_widx  = sp_idx_q;
            mem_wdata = sp_hi_data_q;
            mem_wbe   = sp_hi_be_q;
        end else if (accept && !req_err) begin
            mem_we = req_we;
        end
        // A reset edge commits nothing, so an interrupted split loses beat 1.
        if (!rst_n) mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < B; k++) begin
                if (mem_wbe[k]) mem_q[mem_widx][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == S_IDLE) && accept) begin
            sp_idx_q     <= req_idx_nxt;
            sp_off_q     <= req_off;
            sp_size_q    <= req_size;
            sp_signed_q  <= req_signed;
            sp_we_q      <= req_we;
            sp_hi_data_q <= wide_wdata[DW2-1:DATA_W];
            sp_hi_be_q   <= wide_be[B2-1:B];
            sp_lo_q      <= rd_word_a;
        end
    end

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (crossing && (SPLIT_MISALIGN != 0)) begin
                        state_d = S_SPLIT;
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = req_we ? '0 : extend(ld_raw_a, req_size, req_signed);
                    end
                end
            end
            S_SPLIT: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b1;
                resp_rdata_d = sp_we_q ? '0 : extend(ld_raw_s, sp_size_q, sp_signed_q);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

    // Address bits above the word index alias onto the same memory.
    generate
        if (ADDR_W > OFF_W + IDX_W) begin : g_unused_addr
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[ADDR_W-1:OFF_W+IDX_W];
        end
    endgenerate

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
module tb_dmem_lane_ctrl;

    // Three configurations:
    //   0: 32-bit, errors on misalign, DEPTH 2048
    //   1: 32-bit, split misalign, DEPTH 16
    //   2: 64-bit, split misalign, DEPTH 16
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_we     [3];
    logic [31:0] req_addr   [3];
    logic [1:0]  req_size   [3];
    logic        req_signed [3];
    logic [63:0] req_wdata  [3];
    logic        resp_valid [3];
    logic        resp_err   [3];
    logic [31:0] rd0, rd1;
    logic [63:0] rd2;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mdl [3][8192];

    always #5 clk = ~clk;

    dmem_lane_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(2048), .SPLIT_MISALIGN(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
        .req_signed(req_signed[0]), .req_wdata(req_wdata[0][31:0]),
        .resp_valid(resp_valid[0]), .resp_err(resp_err[0]), .resp_rdata(rd0));

    dmem_lane_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .SPLIT_MISALIGN(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
        .req_signed(req_signed[1]), .req_wdata(req_wdata[1][31:0]),
        .resp_valid(resp_valid[1]), .resp_err(resp_err[1]), .resp_rdata(rd1));

    dmem_lane_ctrl #(.DATA_W(64), .ADDR_W(32), .DEPTH(16), .SPLIT_MISALIGN(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_size(req_size[2]),
        .req_signed(req_signed[2]), .req_wdata(req_wdata[2]),
        .resp_valid(resp_valid[2]), .resp_err(resp_err[2]), .resp_rdata(rd2));

    typedef struct {
        int          sel;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [63:0] wd;
        logic        err;
        logic [63:0] rd;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] get_rdata(input int sel);
        case (sel)
            0:       return {32'h0, rd0};
            1:       return {32'h0, rd1};
            default: return rd2;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic we, input logic [31:0] a,
                         input logic [1:0] sz, input logic sg, input logic [63:0] wd);
        req_valid[sel]  = v;
        req_we[sel]     = we;
        req_addr[sel]   = a;
        req_size[sel]   = sz;
        req_signed[sel] = sg;
        req_wdata[sel]  = wd;
    endtask

    // Byte-addressed reference: memory is a flat byte array that wraps at its
    // total size; an access touches N consecutive bytes, little-endian.
    function automatic void model(input int sel, input logic we, input logic [31:0] addr,
                                  input logic [1:0] size, input logic sgn, input logic [63:0] wd,
                                  output logic err, output logic [63:0] rd, output int lat);
        int          nb, bw, tot, a, off;
        logic        sb;
        bw  = (sel == 2) ? 8 : 4;
        tot = (sel == 0) ? 8192 : (sel == 1) ? 64 : 128;
        nb  = 1 << size;
        off = int'(addr % 32'(bw));
        rd  = '0;
        lat = 1;
        err = (nb > bw) || (((off % nb) != 0) && (sel == 0));
        if (err) return;
        if (off + nb > bw) lat = 2;
        for (int i = 0; i < nb; i++) begin
            a = int'((addr + 32'(i)) % 32'(tot));
            if (we) mdl[sel][a] = wd[8*i +: 8];
            else    rd[8*i +: 8] = mdl[sel][a];
        end
        if (!we) begin
            sb = rd[8*nb-1];
            for (int b = 8*nb; b < 8*bw; b++) rd[b] = sgn & sb;
        end
        else rd = '0;
    endfunction

    // One request; returns response fields, cycles from acceptance to
    // response (0 = no response), ready in the cycle after acceptance, and
    // resp_valid in the cycle after the response.
    task automatic do_req(input int sel, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic sgn, input logic [63:0] wd,
                          output logic err, output logic [63:0] rd, output int lat,
                          output logic rdy_after, output logic rv_after);
        int wait_c;
        @(negedge clk);
        drive(sel, 1'b1, we, addr, size, sgn, wd);
        wait_c = 0;
        while (!req_ready[sel] && wait_c < 20) begin
            @(negedge clk);
            wait_c++;
        end
        @(posedge clk);
        #1;
        req_valid[sel] = 1'b0;
        err = 1'b0; rd = '0; lat = 0; rdy_after = 1'b0; rv_after = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) rdy_after = req_ready[sel];
            if (resp_valid[sel]) begin
                lat = c;
                err = resp_err[sel];
                rd  = get_rdata(sel);
                break;
            end
        end
        @(negedge clk);
        rv_after = resp_valid[sel];
    endtask

    task automatic add(input int sel, input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [63:0] wd, input logic err, input logic [63:0] rd,
                       input int lat);
        vec_t v;
        v.sel = sel; v.we = we; v.addr = addr; v.size = size; v.sgn = sgn; v.wd = wd;
        v.err = err; v.rd = rd; v.lat = lat;
        vecs.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        g_err, g_rdy, g_rv2;
        logic [63:0] g_rd;
        int          g_lat;
        logic        m_err;
        logic [63:0] m_rd;
        int          m_lat;
        logic [31:0] r_addr;
        logic [1:0]  r_size;
        logic        r_we, r_sgn;
        logic [63:0] r_wd;
        int          bw;
        logic [31:0] p_addr [3];
        logic [1:0]  p_size [3];
        logic        p_we   [3];
        logic        p_sgn  [3];
        logic [63:0] p_wd   [3];
        logic [63:0] p_exp  [3];

        for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 64'h0);

        // ---------------- reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst_rv%0d", s), 64'(resp_valid[s]), 64'd0);
            chk($sformatf("rst_err%0d", s), 64'(resp_err[s]), 64'd0);
            chk($sformatf("rst_rd%0d", s), get_rdata(s), 64'd0);
            chk($sformatf("rst_rdy%0d", s), 64'(req_ready[s]), 64'd1);
        end
        rst_n = 1'b1;

        // ---------------- table-driven vectors
        // sel we addr size sgn wdata | err rdata lat
        add(0, 1, 32'h10, 2'd2, 0, 64'h11223344,          0, 64'h0, 1);
        add(0, 0, 32'h12, 2'd0, 0, 64'h0,                 0, 64'h22, 1);
        add(0, 0, 32'h12, 2'd1, 1, 64'h0,                 0, 64'h1122, 1);
        add(0, 1, 32'h13, 2'd0, 0, 64'h80,                0, 64'h0, 1);
        add(0, 0, 32'h10, 2'd2, 0, 64'h0,                 0, 64'h80223344, 1);
        add(0, 0, 32'h13, 2'd0, 1, 64'h0,                 0, 64'hFFFFFF80, 1);
        add(0, 0, 32'h13, 2'd0, 0, 64'h0,                 0, 64'h80, 1);
        add(0, 0, 32'h11, 2'd1, 0, 64'h0,                 1, 64'h0, 1);
        add(0, 1, 32'h11, 2'd2, 0, 64'hDEADBEEF,          1, 64'h0, 1);
        add(0, 0, 32'h10, 2'd2, 0, 64'h0,                 0, 64'h80223344, 1);
        add(0, 0, 32'h10, 2'd3, 0, 64'h0,                 1, 64'h0, 1);
        add(0, 1, 32'h16, 2'd1, 0, 64'h8001,              0, 64'h0, 1);
        add(0, 0, 32'h16, 2'd1, 1, 64'h0,                 0, 64'hFFFF8001, 1);
        add(1, 1, 32'h0C, 2'd2, 0, 64'h0,                 0, 64'h0, 1);
        add(1, 1, 32'h10, 2'd2, 0, 64'h0,                 0, 64'h0, 1);
        add(1, 1, 32'h0E, 2'd2, 0, 64'hAABBCCDD,          0, 64'h0, 2);
        add(1, 0, 32'h0C, 2'd2, 0, 64'h0,                 0, 64'hCCDD0000, 1);
        add(1, 0, 32'h10, 2'd2, 0, 64'h0,                 0, 64'h0000AABB, 1);
        add(1, 0, 32'h0E, 2'd2, 0, 64'h0,                 0, 64'hAABBCCDD, 2);
        add(1, 0, 32'h0D, 2'd1, 0, 64'h0,                 0, 64'hDD00, 1);
        add(1, 1, 32'h3C, 2'd2, 0, 64'h0,                 0, 64'h0, 1);
        add(1, 1, 32'h00, 2'd2, 0, 64'h0,                 0, 64'h0, 1);
        add(1, 1, 32'h3F, 2'd1, 0, 64'hBEEF,              0, 64'h0, 2);
        add(1, 0, 32'h3C, 2'd2, 0, 64'h0,                 0, 64'hEF000000, 1);
        add(1, 0, 32'h00, 2'd2, 0, 64'h0,                 0, 64'h000000BE, 1);
        add(1, 0, 32'h00, 2'd3, 0, 64'h0,                 1, 64'h0, 1);
        add(2, 1, 32'h08, 2'd3, 0, 64'hF123456789ABCDEF,  0, 64'h0, 1);
        add(2, 0, 32'h08, 2'd3, 1, 64'h0,                 0, 64'hF123456789ABCDEF, 1);
        add(2, 0, 32'h0C, 2'd2, 1, 64'h0,                 0, 64'hFFFFFFFFF1234567, 1);
        add(2, 1, 32'h0C, 2'd3, 0, 64'h1122334455667788,  0, 64'h0, 2);
        add(2, 0, 32'h0C, 2'd3, 0, 64'h0,                 0, 64'h1122334455667788, 2);
        add(2, 0, 32'h08, 2'd3, 0, 64'h0,                 0, 64'h5566778889ABCDEF, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].sgn, vecs[i].wd,
                   g_err, g_rd, g_lat, g_rdy, g_rv2);
            chk($sformatf("vec%0d_err", i), 64'(g_err), 64'(vecs[i].err));
            chk($sformatf("vec%0d_rdata", i), g_rd, vecs[i].rd);
            chk($sformatf("vec%0d_latency", i), 64'(g_lat), 64'(vecs[i].lat));
            chk($sformatf("vec%0d_ready_after", i), 64'(g_rdy), (vecs[i].lat == 2) ? 64'd0 : 64'd1);
            chk($sformatf("vec%0d_pulse", i), 64'(g_rv2), 64'd0);
        end

        // ---------------- back-to-back aligned traffic, one per cycle
        p_we[0] = 1; p_addr[0] = 32'h40; p_size[0] = 2'd2; p_sgn[0] = 0; p_wd[0] = 64'hCAFEF00D; p_exp[0] = 64'h0;
        p_we[1] = 0; p_addr[1] = 32'h41; p_size[1] = 2'd0; p_sgn[1] = 0; p_wd[1] = 64'h0;        p_exp[1] = 64'hF0;
        p_we[2] = 0; p_addr[2] = 32'h42; p_size[2] = 2'd1; p_sgn[2] = 1; p_wd[2] = 64'h0;        p_exp[2] = 64'hFFFFCAFE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("b2b%0d_rv", i-1), 64'(resp_valid[0]), 64'd1);
                chk($sformatf("b2b%0d_rdata", i-1), get_rdata(0), p_exp[i-1]);
            end
            if (i < 3) begin
                drive(0, 1'b1, p_we[i], p_addr[i], p_size[i], p_sgn[i], p_wd[i]);
                chk($sformatf("b2b%0d_ready", i), 64'(req_ready[0]), 64'd1);
            end else begin
                req_valid[0] = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_idle_rv", 64'(resp_valid[0]), 64'd0);

        // ---------------- reset during the SPLIT beat of a crossing store
        do_req(1, 1, 32'h20, 2'd2, 0, 64'h0, g_err, g_rd, g_lat, g_rdy, g_rv2);
        do_req(1, 1, 32'h24, 2'd2, 0, 64'h0, g_err, g_rd, g_lat, g_rdy, g_rv2);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 32'h22, 2'd2, 1'b0, 64'hAABBCCDD);
        chk("rstsplit_ready", 64'(req_ready[1]), 64'd1);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstsplit_busy", 64'(req_ready[1]), 64'd0);
        chk("rstsplit_rv_split", 64'(resp_valid[1]), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstsplit_rv_after", 64'(resp_valid[1]), 64'd0);
        chk("rstsplit_ready_after", 64'(req_ready[1]), 64'd1);
        do_req(1, 0, 32'h20, 2'd2, 0, 64'h0, g_err, g_rd, g_lat, g_rdy, g_rv2);
        chk("rstsplit_beat0_word", g_rd, 64'hCCDD0000);
        do_req(1, 0, 32'h24, 2'd2, 0, 64'h0, g_err, g_rd, g_lat, g_rdy, g_rv2);
        chk("rstsplit_beat1_word", g_rd, 64'h0);

        // ---------------- randomized traffic against the byte-array model
        for (int s = 0; s < 3; s++) begin
            bw = (s == 2) ? 8 : 4;
            for (int w = 0; w < 16; w++) begin
                r_addr = 32'(w * bw);
                r_size = (bw == 8) ? 2'd3 : 2'd2;
                r_wd   = {$urandom, $urandom};
                model(s, 1'b1, r_addr, r_size, 1'b0, r_wd, m_err, m_rd, m_lat);
                do_req(s, 1'b1, r_addr, r_size, 1'b0, r_wd, g_err, g_rd, g_lat, g_rdy, g_rv2);
                chk($sformatf("init%0d_%0d_err", s, w), 64'(g_err), 64'(m_err));
            end
            for (int n = 0; n < 80; n++) begin
                r_addr = 32'($urandom_range(0, 16 * bw - 1)) | (32'($urandom_range(0, 3)) << 16);
                r_size = 2'($urandom_range(0, 3));
                r_we   = 1'($urandom_range(0, 1));
                r_sgn  = 1'($urandom_range(0, 1));
                r_wd   = {$urandom, $urandom};
                model(s, r_we, r_addr, r_size, r_sgn, r_wd, m_err, m_rd, m_lat);
                do_req(s, r_we, r_addr, r_size, r_sgn, r_wd, g_err, g_rd, g_lat, g_rdy, g_rv2);
                chk($sformatf("rnd%0d_%0d_err a=%h sz=%0d we=%0d", s, n, r_addr, r_size, r_we),
                    64'(g_err), 64'(m_err));
                chk($sformatf("rnd%0d_%0d_rdata a=%h sz=%0d we=%0d", s, n, r_addr, r_size, r_we),
                    g_rd, m_rd);
                chk($sformatf("rnd%0d_%0d_latency", s, n), 64'(g_lat), 64'(m_lat));
                chk($sformatf("rnd%0d_%0d_pulse", s, n), 64'(g_rv2), 64'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_lane_ctrl.md
Name: dmem_lane_ctrl

Overview:
Parametrised byte-lane data memory with a valid/ready request port and registered responses. It is the next-generation data memory for the multi-cycle core. It supports byte, half, word and (at 64-bit width) doubleword access, with sign or zero extension on reads. Misaligned accesses are either flagged as errors or split automatically into two back-to-back word accesses, selected by parameter.

Parameters:
DATA_W, 32, memory word width in bits; legal values are 32 and 64; B = DATA_W/8 byte lanes.
ADDR_W, 32, byte address width.
DEPTH, 2048, number of memory words; power of two.
SPLIT_MISALIGN, 0, 0 = misaligned access returns an error; 1 = misaligned access is executed, crossing accesses take two beats.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  request accepted when req_valid && req_ready.
req_we  in  1  1 = store, 0 = load.
req_addr  in  ADDR_W  byte address.
req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 dword.
req_signed  in  1  load result is sign-extended when set, zero-extended when clear.
req_wdata  in  DATA_W  store data, right-justified.
resp_valid  out  1  single-cycle response pulse; there is no backpressure on the response.
resp_err  out  1  the access was rejected; valid with resp_valid.
resp_rdata  out  DATA_W  load result, right-justified and extended; 0 for stores and errors.

Behaviour:
- Reset:
  - Applied synchronously when rst_n = 0 at a clk edge.
  - state = IDLE, resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - Memory array contents are not reset.
- Derived quantities:
  - N = 1 << req_size bytes.
  - o = req_addr[log2(B)-1:0].
  - idx = req_addr[log2(B)+log2(DEPTH)-1 : log2(B)].
  - idx+1 wraps modulo DEPTH.
- Lane order is little-endian: byte lane k is bits [8k+7:8k].
- Classification of an accepted request:
  - Illegal: req_size = 11 with DATA_W = 32.
  - Misaligned: (o mod N) != 0.
  - Crossing: o + N > B.
- req_ready = (state == IDLE). Aligned traffic sustains one request per cycle.
- Aligned access, accepted at edge T:
  - Store: lanes o..o+N-1 of word idx are written at T with req_wdata[8N-1:0] shifted left by 8*o. All other lanes are unchanged.
  - Load: the word is read synchronously.
  - resp_valid = 1 during cycle T+1. For a load, resp_rdata = bytes o..o+N-1, extended from bit 8N-1.
- Illegal, or misaligned with SPLIT_MISALIGN = 0:
  - No memory write.
  - resp_valid = 1 and resp_err = 1 at T+1; resp_rdata = 0.
  - State stays IDLE.
- SPLIT_MISALIGN = 1, misaligned but not crossing: handled exactly as an aligned access (single beat).
- SPLIT_MISALIGN = 1, crossing:
  - State goes to SPLIT for one cycle; req_ready = 0 in that cycle.
  - Beat 0 (edge T), word idx: store writes lanes o..B-1 with the low B-o bytes of the data; load captures those bytes as result bytes 0..B-o-1.
  - Beat 1 (edge T+1), word idx+1: store writes lanes 0..o+N-B-1 with the remaining high bytes; load supplies result bytes B-o..N-1.
  - resp_valid = 1 at T+2; state returns to IDLE.
  - Request fields are captured at T. Input changes during SPLIT are ignored.
- Extension: the bits above 8N are filled with (req_signed && result bit 8N-1). For dword on 64-bit the result is not extended.
- Reset during SPLIT: beat 0 may already be committed, beat 1 is not performed, and no response is issued.
- resp_err is 0 for all successful accesses.
- resp_valid is deasserted in every cycle that does not carry a response.

Test Plan:
- DATA_W=32: store word 0x11223344 at 0x10. Then load byte at 0x12 with signed=0 -> 0x00000022. Load half at 0x12 with signed=1 -> 0x00001122. Each response arrives 1 cycle after acceptance; req_ready stays high throughout.
- Store byte 0x80 at 0x13, then load word at 0x10 -> 0x80223344. Load byte at 0x13 signed -> 0xFFFFFF80; unsigned -> 0x00000080.
- SPLIT_MISALIGN=0: load half at 0x11 -> resp_err=1 and rdata=0. A following word load at 0x10 confirms memory is unchanged. req_size=11 with DATA_W=32 -> resp_err=1.
- SPLIT_MISALIGN=1: store word 0xAABBCCDD at 0x0E (two words pre-zeroed).
  - req_ready is low for 1 cycle and resp_valid arrives at T+2.
  - Word 0x0C reads 0xCCDD0000; word 0x10 reads 0x0000AABB.
  - Word load at 0x0E returns 0xAABBCCDD.
- Wrap-around: DEPTH=16, SPLIT_MISALIGN=1, half store 0xBEEF at byte address 0x3F -> lane 3 of word 15 = 0xEF and lane 0 of word 0 = 0xBE.
- rst_n low during the SPLIT cycle of a crossing store: no resp_valid, req_ready high the next cycle, beat 0 lanes written, beat 1 lanes untouched. DATA_W=64 dword load at 0x8 returns all 8 bytes unmodified.
